// File: rtl/shift_in_frame.sv
// Serial-to-parallel deserialiser: collects WIDTH bits per frame (MSB- or LSB-first) and double-buffers each word into data_out.
// Latency: valid/data_out update on the clk edge that samples the final bit of a frame, so they are visible the cycle after it.
// Backpressure: valid holds until ready; a frame completing while an unaccepted word is held is dropped and sets sticky overrun.
//
// Optional build macro SHIFT_IN_PARITY_EN: each frame carries one extra trailing even-parity bit,
// which is checked but not stored, and a parity_err output is registered alongside data_out.

module shift_in_frame #(
    parameter int WIDTH     = 12,   // data bits per frame, 2..32
    parameter int MSB_FIRST = 1,    // 1: first bit lands in data_out[WIDTH-1]; 0: in data_out[0]
    parameter int CNT_W     = 5     // 2**CNT_W must exceed the frame length
) (
    input  logic             clk,
    input  logic             rst,          // asynchronous, active low
    input  logic             data_in,
    input  logic             ena,
    input  logic             frame_start,
    output logic [WIDTH-1:0] data_out,
    output logic             valid,
    input  logic             ready,
    output logic             busy,
    output logic [CNT_W-1:0] bit_cnt,
    output logic             overrun
`ifdef SHIFT_IN_PARITY_EN
    ,
    output logic             parity_err
`endif
);

    // ------------------------------------------------------------------
    // Frame geometry
    // ------------------------------------------------------------------
`ifdef SHIFT_IN_PARITY_EN
    localparam int PAR_BITS = 1;
`else
    localparam int PAR_BITS = 0;
`endif

    // Total bits per frame on the wire, including the parity bit when present.
    localparam int FRAME_LEN = WIDTH + PAR_BITS;

    // bit_cnt value at which the incoming bit closes the frame.
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_LEN - 1);

    // ------------------------------------------------------------------
    // Internal state
    // ------------------------------------------------------------------
    // Assembly register, kept apart from data_out so a new frame can be
    // collected while the previous word waits for the consumer.
    logic [WIDTH-1:0] sreg;

    // ------------------------------------------------------------------
    // Next-state helpers
    // ------------------------------------------------------------------
    // Counter / assembly values as seen by this cycle's bit. A realignment
    // pulse makes the current bit behave as bit 0 of a fresh frame, so the
    // partial frame is discarded before the bit is shifted in.
    logic [CNT_W-1:0] cnt_base;
    logic [WIDTH-1:0] sreg_base;
    logic [WIDTH-1:0] sreg_shift;
    logic             frame_done;
    logic [WIDTH-1:0] word_next;
    logic             load_word;
    logic             drop_word;
    logic             accept;
`ifdef SHIFT_IN_PARITY_EN
    logic             perr_next;
`endif

    // Realignment-aware base values and the shifted assembly word.
    always_comb begin
        cnt_base   = bit_cnt;
        sreg_base  = sreg;
        sreg_shift = '0;
        if (frame_start) begin
            cnt_base  = '0;
            sreg_base = '0;
        end
        if (MSB_FIRST != 0) begin
            // Earliest bit migrates toward the MSB; newest bit enters at bit 0.
            sreg_shift = {sreg_base[WIDTH-2:0], data_in};
        end else begin
            // Earliest bit migrates toward bit 0; newest bit enters at the MSB.
            sreg_shift = {data_in, sreg_base[WIDTH-1:1]};
        end
    end

    // Frame completion and the word to be handed to the output stage.
    always_comb begin
        frame_done = ena && (cnt_base == LAST_CNT);
`ifdef SHIFT_IN_PARITY_EN
        // The closing bit is the parity bit: the data bits are already
        // fully assembled, and the parity bit itself is never stored.
        word_next  = sreg_base;
        // Even parity: data bits plus parity bit must XOR to zero.
        perr_next  = (^sreg_base) ^ data_in;
`else
        // The closing bit is the last data bit, so include it now.
        word_next  = sreg_shift;
`endif
    end

    // Output-stage decisions for this cycle.
    always_comb begin
        accept    = valid && ready;
        // A completed word is taken if the holding register is free or is
        // being emptied in this same cycle.
        load_word = frame_done && (!valid || ready);
        // Otherwise the new word has nowhere to go and is lost.
        drop_word = frame_done && valid && !ready;
    end

    // ------------------------------------------------------------------
    // Bit counter and assembly register
    // ------------------------------------------------------------------
    // Advance one bit per ena, restart on frame completion or realignment.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bit_cnt <= '0;
            sreg    <= '0;
        end else if (frame_done) begin
            bit_cnt <= '0;
            sreg    <= '0;
        end else if (ena) begin
            bit_cnt <= cnt_base + CNT_W'(1);
            sreg    <= sreg_shift;
        end else if (frame_start) begin
            bit_cnt <= '0;
            sreg    <= '0;
        end
    end

    // ------------------------------------------------------------------
    // Output holding register and handshake
    // ------------------------------------------------------------------
    // Load a completed word when there is room; clear valid on acceptance.
    // data_out keeps its last value after acceptance.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_out <= '0;
            valid    <= 1'b0;
        end else if (load_word) begin
            data_out <= word_next;
            valid    <= 1'b1;
        end else if (accept) begin
            valid    <= 1'b0;
        end
    end

`ifdef SHIFT_IN_PARITY_EN
    // Parity status travels with the word it describes; dropped frames leave it alone.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            parity_err <= 1'b0;
        end else if (load_word) begin
            parity_err <= perr_next;
        end
    end
`endif

    // Sticky drop flag; only realignment or reset clears it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overrun <= 1'b0;
        end else if (frame_start) begin
            overrun <= 1'b0;
        end else if (drop_word) begin
            overrun <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Status
    // ------------------------------------------------------------------
    // A frame is in progress whenever at least one bit has been collected.
    always_comb begin
        busy = (bit_cnt != '0);
    end

endmodule

// File: tb/tb_shift_in_frame.sv
// Scoreboard bench for shift_in_frame: one MSB-first and one LSB-first instance.
// Expected words are queued as frames are sent; monitors pop and compare on each accepted word.
// Directed checks cover reset, latency, overrun, ena gaps, realignment and mid-frame reset.

module tb_shift_in_frame;

`ifdef SHIFT_IN_PARITY_EN
    localparam int FL = 13;
`else
    localparam int FL = 12;
`endif

    typedef struct {
        logic [11:0] w;
        logic        pe;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        data_in;
    logic        ena;
    logic        ena_l;
    logic        frame_start;
    logic        ready;
    logic        ready_l;
    logic [11:0] data_out;
    logic [11:0] data_out_l;
    logic        valid;
    logic        valid_l;
    logic        busy;
    logic        busy_l;
    logic [4:0]  bit_cnt;
    logic [4:0]  bit_cnt_l;
    logic        overrun;
    logic        overrun_l;
`ifdef SHIFT_IN_PARITY_EN
    logic        perr;
    logic        perr_l;
`endif

    exp_t q[$];
    exp_t q_l[$];

    int n_checks = 0;
    int n_pass   = 0;

    shift_in_frame #(.WIDTH(12), .MSB_FIRST(1), .CNT_W(5)) dut (
        .clk(clk), .rst(rst), .data_in(data_in), .ena(ena), .frame_start(frame_start),
        .data_out(data_out), .valid(valid), .ready(ready), .busy(busy),
        .bit_cnt(bit_cnt), .overrun(overrun)
`ifdef SHIFT_IN_PARITY_EN
        , .parity_err(perr)
`endif
    );

    shift_in_frame #(.WIDTH(12), .MSB_FIRST(0), .CNT_W(5)) dut_l (
        .clk(clk), .rst(rst), .data_in(data_in), .ena(ena_l), .frame_start(frame_start),
        .data_out(data_out_l), .valid(valid_l), .ready(ready_l), .busy(busy_l),
        .bit_cnt(bit_cnt_l), .overrun(overrun_l)
`ifdef SHIFT_IN_PARITY_EN
        , .parity_err(perr_l)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t, limit 100000", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    endtask

    // One bit on the selected instance's strobe; back-to-back calls keep ena high.
    task automatic drive_bit(input logic d, input bit lsb);
        data_in = d;
        if (lsb) ena_l = 1'b1;
        else     ena   = 1'b1;
        @(posedge clk);
        #1;
        ena   = 1'b0;
        ena_l = 1'b0;
    endtask

    // Send w on the wire MSB-first (plus a correct even-parity bit when enabled).
    task automatic send(input logic [11:0] w, input logic [11:0] expw, input bit lsb, input bit push);
        exp_t e;
        e.w  = expw;
        e.pe = 1'b0;
        if (push) begin
            if (lsb) q_l.push_back(e);
            else     q.push_back(e);
        end
        for (int i = 11; i >= 0; i--) drive_bit(w[i], lsb);
`ifdef SHIFT_IN_PARITY_EN
        drive_bit(^w, lsb);
`endif
    endtask

    // Scoreboard monitor, MSB-first instance: compare each accepted word.
    always @(negedge clk) begin
        if (rst && valid && ready) begin
            if (q.size() == 0) begin
                n_checks++;
                $display("FAIL sb_msb_unexpected: got word 0x%0h, want no word", data_out);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("sb_msb_data", 32'(data_out), 32'(e.w));
`ifdef SHIFT_IN_PARITY_EN
                chk("sb_msb_perr", 32'(perr), 32'(e.pe));
`endif
            end
        end
    end

    // Scoreboard monitor, LSB-first instance.
    always @(negedge clk) begin
        if (rst && valid_l && ready_l) begin
            if (q_l.size() == 0) begin
                n_checks++;
                $display("FAIL sb_lsb_unexpected: got word 0x%0h, want no word", data_out_l);
            end else begin
                exp_t e;
                e = q_l.pop_front();
                chk("sb_lsb_data", 32'(data_out_l), 32'(e.w));
`ifdef SHIFT_IN_PARITY_EN
                chk("sb_lsb_perr", 32'(perr_l), 32'(e.pe));
`endif
            end
        end
    end

    initial begin
        logic [11:0] w4;
        int          exp_cnt;
        int          gap;

        rst = 1'b0; data_in = 1'b0; ena = 1'b0; ena_l = 1'b0;
        frame_start = 1'b0; ready = 1'b1; ready_l = 1'b1;
        #1;
        // Reset state
        chk("rst_data_out", 32'(data_out), 32'h0);
        chk("rst_valid",    32'(valid),    32'h0);
        chk("rst_overrun",  32'(overrun),  32'h0);
        chk("rst_bit_cnt",  32'(bit_cnt),  32'h0);
        chk("rst_busy",     32'(busy),     32'h0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;

        // 1: MSB-first 0xA5C, ready high
        send(12'hA5C, 12'hA5C, 1'b0, 1'b1);
        chk("t1_valid",    32'(valid),    32'h1);
        chk("t1_data_out", 32'(data_out), 32'hA5C);
        chk("t1_bit_cnt",  32'(bit_cnt),  32'h0);
        chk("t1_busy",     32'(busy),     32'h0);
        @(posedge clk); #1;
        chk("t1_valid_drop", 32'(valid), 32'h0);
        chk("t1_hold_data",  32'(data_out), 32'hA5C);

        // 2: LSB-first instance, same bit stream -> bit-reversed word
        send(12'hA5C, 12'h3A5, 1'b1, 1'b1);
        chk("t2_valid",    32'(valid_l),    32'h1);
        chk("t2_data_out", 32'(data_out_l), 32'h3A5);
        @(posedge clk); #1;

        // 3: backpressure and overrun
        ready = 1'b0;
        send(12'h123, 12'h123, 1'b0, 1'b1);
        chk("t3_valid1",   32'(valid),    32'h1);
        chk("t3_overrun0", 32'(overrun),  32'h0);
        send(12'h456, 12'h456, 1'b0, 1'b0);
        chk("t3_data_kept", 32'(data_out), 32'h123);
        chk("t3_overrun1",  32'(overrun),  32'h1);
        chk("t3_valid2",    32'(valid),    32'h1);
        ready = 1'b1;
        @(posedge clk); #1;
        ready = 1'b0;
        chk("t3_valid_acc",  32'(valid),   32'h0);
        chk("t3_ovr_sticky", 32'(overrun), 32'h1);
        frame_start = 1'b1;
        @(posedge clk); #1;
        frame_start = 1'b0;
        chk("t3_ovr_clear",  32'(overrun), 32'h0);
        chk("t3_valid_keep", 32'(valid),   32'h0);
        ready = 1'b1;

        // 4: ena with random gaps; bit_cnt moves only on ena
        w4 = 12'h0F0;
        exp_cnt = 0;
        q.push_back('{w: 12'h0F0, pe: 1'b0});
        for (int i = 11; i >= 0; i--) begin
            gap = $urandom_range(0, 2);
            repeat (gap) begin
                data_in = ~data_in;
                @(posedge clk); #1;
                chk("t4_gap_cnt", 32'(bit_cnt), 32'(exp_cnt));
            end
            drive_bit(w4[i], 1'b0);
            exp_cnt = (exp_cnt + 1) % FL;
            chk("t4_ena_cnt", 32'(bit_cnt), 32'(exp_cnt));
            chk("t4_busy",    32'(busy),    32'(exp_cnt != 0));
        end
`ifdef SHIFT_IN_PARITY_EN
        @(posedge clk); #1;
        drive_bit(1'b0, 1'b0);
`endif
        chk("t4_data_out", 32'(data_out), 32'h0F0);
        chk("t4_valid",    32'(valid),    32'h1);
        @(posedge clk); #1;

        // 5: aborted partial frame, realignment with a bit on the same cycle
        drive_bit(1'b1, 1'b0);
        drive_bit(1'b0, 1'b0);
        drive_bit(1'b1, 1'b0);
        drive_bit(1'b1, 1'b0);
        drive_bit(1'b0, 1'b0);
        chk("t5_partial_cnt", 32'(bit_cnt), 32'h5);
        q.push_back('{w: 12'hFFF, pe: 1'b0});
        data_in = 1'b1; ena = 1'b1; frame_start = 1'b1;
        @(posedge clk); #1;
        ena = 1'b0; frame_start = 1'b0;
        chk("t5_realign_cnt", 32'(bit_cnt), 32'h1);
        repeat (11) drive_bit(1'b1, 1'b0);
`ifdef SHIFT_IN_PARITY_EN
        drive_bit(1'b0, 1'b0);
`endif
        chk("t5_data_out", 32'(data_out), 32'hFFF);
        chk("t5_valid",    32'(valid),    32'h1);
        @(posedge clk); #1;

        // 5b: asynchronous reset mid-frame
        repeat (5) drive_bit(1'b1, 1'b0);
        #2 rst = 1'b0;
        #1;
        chk("t5_arst_data_out", 32'(data_out), 32'h0);
        chk("t5_arst_valid",    32'(valid),    32'h0);
        chk("t5_arst_bit_cnt",  32'(bit_cnt),  32'h0);
        chk("t5_arst_busy",     32'(busy),     32'h0);
        chk("t5_arst_overrun",  32'(overrun),  32'h0);
        @(posedge clk); #1;
        rst = 1'b1;
        send(12'h5A3, 12'h5A3, 1'b0, 1'b1);
        chk("t5_after_rst_data", 32'(data_out), 32'h5A3);
        @(posedge clk); #1;

`ifdef SHIFT_IN_PARITY_EN
        // 6: parity good then bad
        q.push_back('{w: 12'h001, pe: 1'b0});
        for (int i = 11; i >= 0; i--) drive_bit(i == 0, 1'b0);
        drive_bit(1'b1, 1'b0);
        chk("t6_perr_good", 32'(perr),     32'h0);
        chk("t6_data_good", 32'(data_out), 32'h001);
        @(posedge clk); #1;
        q.push_back('{w: 12'h001, pe: 1'b1});
        for (int i = 11; i >= 0; i--) drive_bit(i == 0, 1'b0);
        drive_bit(1'b0, 1'b0);
        chk("t6_perr_bad", 32'(perr),     32'h1);
        chk("t6_data_bad", 32'(data_out), 32'h001);
        @(posedge clk); #1;
`endif

        repeat (3) @(posedge clk);
        #1;
        chk("sb_msb_drained", 32'(q.size()),   32'h0);
        chk("sb_lsb_drained", 32'(q_l.size()), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/shift_in_frame.md
Name: shift_in_frame

Overview:
Parametrised serial-to-parallel deserialiser for ADC and sensor serial links. It is the successor to the fixed 12-bit mask-based shift-in.
- Counts bits per frame and selects MSB-first or LSB-first order.
- Double-buffers each completed word into an output register.
- Hands the word off with a valid/ready handshake and flags overrun.
- Sits between the serial-link timing logic, which drives ena, and downstream sample-processing logic.

Parameters:
- WIDTH, 12, data bits per frame (range 2..32).
- MSB_FIRST, 1, 1 = first received bit lands in data_out[WIDTH-1]; 0 = first bit lands in data_out[0].
- CNT_W, 5, bit-counter width; must satisfy 2^CNT_W > WIDTH (WIDTH+1 when parity is enabled).

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  asynchronous active-low reset.
- data_in  in  1  serial data bit, sampled when ena=1.
- ena  in  1  bit strobe; one bit accepted per clk with ena=1.
- frame_start  in  1  synchronous realignment; aborts any partial frame.
- data_out  out  WIDTH  last completed word.
- valid  out  1  data_out holds an unaccepted word.
- ready  in  1  consumer accepts the word when valid&ready.
- busy  out  1  partial frame in progress (bit_cnt != 0).
- bit_cnt  out  CNT_W  bits received in the current frame.
- overrun  out  1  sticky: a completed frame was dropped.

Behaviour:
- Reset (rst=0, async): data_out=0, valid=0, overrun=0, bit_cnt=0, busy=0, shift register=0.
- Shift register is internal and separate from data_out, so shifting continues while data_out is held.
- Shift on ena=1:
  - MSB_FIRST=1: shift left, new bit enters LSB.
  - MSB_FIRST=0: shift right, new bit enters MSB.
  - bit_cnt increments on each accepted bit.
- Frame completion: ena=1 with bit_cnt=WIDTH-1 (the final bit).
  - At that same posedge the full word, including the final bit, is presented to the output stage.
  - bit_cnt and the shift register clear to 0.
  - Latency: valid and the new data_out are visible in the cycle after the edge that sampled the last bit.
- Output stage on a completed frame:
  - valid=0: load data_out, set valid=1.
  - valid=1 and ready=1 in the same cycle: load the new word, valid stays 1, no overrun.
  - valid=1 and ready=0: keep the old data_out, drop the new word, set overrun=1.
- Acceptance: valid&ready with no completing frame clears valid the next cycle. data_out keeps its last value and is not cleared.
- frame_start=1:
  - Clears bit_cnt, the shift register and overrun.
  - If ena=1 in the same cycle, that data_in bit is taken as bit 0 of the new frame, so bit_cnt=1 afterwards.
  - If that bit would complete a WIDTH=1 frame: not applicable, since WIDTH>=2.
  - valid and data_out are not affected.
- ena=0: all state holds; ready still acts on valid.
- busy is combinational from bit_cnt (busy = bit_cnt != 0).
- overrun clears only on reset or frame_start.
- Reset mid-frame: partial data is discarded and the next bit after release is bit 0.

Optional Feature:
SHIFT_IN_PARITY_EN
- Defined:
  - Frame length is WIDTH+1. The extra final bit is an even-parity bit over the WIDTH data bits and is not stored in data_out.
  - Adds output port parity_err (1 bit). It is registered with data_out on each load: 1 when XOR(data bits, parity bit) = 1. Reset value 0.
  - A dropped frame never updates parity_err.
- Undefined:
  - Frame length is WIDTH.
  - parity_err port and its logic are absent.

Test Plan:
1. WIDTH=12, MSB_FIRST=1, ready=1. Send 0xA5C MSB-first with ena=1 for 12 consecutive cycles. Expect: valid=1 the cycle after the 12th bit; data_out=0xA5C; bit_cnt returns to 0; valid drops the next cycle.
2. MSB_FIRST=0, same bit stream (first bit 1, ...). Expect data_out=0x3A5, i.e. the bit-reversed 0xA5C.
3. ready=0. Send 0x123, then 0x456. Expect: data_out stays 0x123, overrun=1, valid=1. Pulse ready: valid=0. Pulse frame_start: overrun=0.
4. Gaps in ena. Send 0x0F0 with ena toggling 1/0 and random gaps. Expect identical data_out=0x0F0, and bit_cnt advances only on ena cycles.
5. Send 5 bits, then frame_start together with ena and data_in=1, then 11 more bits of 0xFFF. Expect data_out=0xFFF with no trace of the aborted bits. Assert rst mid-frame: all outputs 0 immediately, without waiting for clk.
6. With SHIFT_IN_PARITY_EN defined: send 0x001 with parity bit 1, expect parity_err=0. Then send 0x001 with parity bit 0, expect parity_err=1. data_out=0x001 in both cases.
